mem_block_adapter: RTL
======================

# mem_block_adapter

Block-transfer engine sitting directly below the cache controller, on its lower-level side. It accepts one 4-word (16-byte) cache-block request per handshake: either a write-back of a dirty block or a fill of a missing block. It serialises each request into four single-word beats on a 32-bit word memory port. When the transfer is finished it returns a one-cycle `Rdy_Low` pulse, and for fills it presents the assembled block on `Dout_Low`.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum consecutive stall cycles allowed within one beat before the transfer is aborted; range 1..255.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Req_Low`  in  1  block request from the cache controller; a level signal, sampled only in IDLE.
- `Wr_Low`  in  1  request type: 1 = write-back, 0 = fill; sampled with `Req_Low`.
- `A_Low`  in  28  block address, byte address bits [31:4].
- `Din_Low`  in  128  write-back data; word i occupies bits [32i+31:32i].
- `Rdy_Low`  out  1  one-cycle completion pulse to the controller.
- `Err_Low`  out  1  asserted together with `Rdy_Low` when the transfer aborted on timeout.
- `Dout_Low`  out  128  fill data, same word packing as `Din_Low`.
- `Mem_Req`  out  1  beat request to memory.
- `Mem_Wr`  out  1  beat direction: 1 = write.
- `Mem_Addr`  out  32  beat byte address.
- `Mem_WData`  out  32  beat write data.
- `Mem_RData`  in  32  beat read data; valid when `Mem_Ack` = 1.
- `Mem_Ack`  in  1  beat completes in any cycle where `Mem_Req` and `Mem_Ack` are both 1.

## Operation
- FSM states: IDLE, XFER, DONE.
  - 2-bit beat counter.
  - 8-bit stall counter.
  - Latched address, direction and data.
- IDLE:
  - `Mem_Req` = 0 and `Rdy_Low` = 0.
  - If `Req_Low` = 1, latch `A_Low`, `Wr_Low` and `Din_Low`, clear beat and stall counters, and go to XFER.
- XFER:
  - `Mem_Req` = 1 and `Mem_Wr` = latched direction.
  - `Mem_Addr` = {latched addr, beat, 2'b00}.
  - `Mem_WData` = latched word[beat].
- On a completed beat (`Mem_Ack` = 1):
  - For a fill, write `Mem_RData` into `Dout_Low` word[beat]. For a write-back, `Dout_Low` is unchanged.
  - Clear the stall counter.
  - If beat = 3 go to DONE; otherwise increment beat.
- On a stall (`Mem_Ack` = 0):
  - Increment the stall counter.
  - If it reaches `TIMEOUT`, set the error flag and go to DONE. Words not yet filled keep their previous `Dout_Low` value.
- DONE:
  - `Rdy_Low` = 1 and `Err_Low` = error flag, for exactly one cycle.
  - Clear the error flag and return to IDLE unconditionally.
- Because DONE always passes through IDLE, a request that is still held high is re-sampled only on the cycle after `Rdy_Low`. This gives correct write-back→fill chaining, where `Req_Low` stays high while `Wr_Low` falls. It also means a request that has just completed and then drops is never re-triggered.
- Outside IDLE, changes on `Req_Low`, `Wr_Low`, `A_Low` and `Din_Low` are ignored. Deasserting `Req_Low` mid-transfer does not abort the transfer.
- In IDLE and DONE, `Mem_Addr`, `Mem_WData` and `Mem_Wr` hold their last values, and `Mem_Req` = 0.

## Timing
- All outputs are driven from registers. There is no combinational path from any input to any output.
- Reset values:
  - state = IDLE.
  - `Rdy_Low`, `Err_Low`, `Mem_Req` and `Mem_Wr` = 0.
  - `Mem_Addr`, `Mem_WData` and `Dout_Low` = 0.
  - Beat counter, stall counter and error flag = 0.
- Latency, with `Req_Low` first high in cycle N and `Mem_Ack` tied high:
  - `Mem_Req` is high in cycles N+1..N+4, carrying beats 0..3 in order.
  - `Rdy_Low` is high in cycle N+5.
  - Each stall cycle adds one cycle to this.
- `Dout_Low` is stable from the `Rdy_Low` cycle until the next fill's first completed beat.
- Timeout: `Rdy_Low`/`Err_Low` rise in the cycle after the `TIMEOUT`-th consecutive stall cycle of a beat.
- `rst` is synchronous and overrides everything. Asserted mid-transfer, `Mem_Req` is 0 in the following cycle and no `Rdy_Low` is produced for the aborted request.
- Back-to-back requests take at least 6 cycles each: IDLE, XFER×4, DONE.

## Test plan
- Fill:
  - Stimulus: `A_Low` = 28'h0000123, `Wr_Low` = 0; memory returns 32'hA0..A3 for addresses 0x1230/4/8/C with `Ack` held high.
  - Required: `Mem_Addr` sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - Required: `Rdy_Low` in cycle N+5 with `Dout_Low` = {A3,A2,A1,A0}.
- Write-back→fill chain:
  - Stimulus: `Req_Low` held high, `Wr_Low` = 1 for the first transfer, dropping to 0 the cycle after `Rdy_Low`.
  - Required: 4 write beats carrying `Din_Low` words, then 4 read beats, then two distinct `Rdy_Low` pulses.
- Stalls:
  - Stimulus: `Ack` low for 3 cycles before beat 2.
  - Required: `Mem_Addr` holds 0x…8 for 4 cycles.
  - Required: `Rdy_Low` at N+8.
- Timeout:
  - Stimulus: `TIMEOUT` = 4, `Ack` never asserted.
  - Required: `Mem_Req` high for 4 cycles, then `Rdy_Low` = `Err_Low` = 1 for one cycle, then IDLE.
- Reset mid-beat:
  - Stimulus: `rst` asserted during beat 1 of a fill.
  - Required: next cycle `Mem_Req` = 0 and `Dout_Low` = 0.
  - Required: no `Rdy_Low`; a new request after reset completes normally.
- Spurious inputs:
  - Stimulus: `A_Low`/`Din_Low` changed mid-transfer, and `Req_Low` dropped at beat 1.
  - Required: the transfer uses the latched values, completes, and asserts `Rdy_Low` once.

Source files
------------

// File: rtl/mem_block_adapter.sv
// Block-transfer engine below the cache controller: one 4-word block per
// request, serialised into four 32-bit word beats on the memory port.
// All outputs come straight from flops, computed one cycle ahead from the
// next-state values.
//
// state | meaning
// IDLE  | waiting for Req_Low; request fields are latched here only
// XFER  | one beat per cycle on the memory port, stalls while Mem_Ack = 0
// DONE  | one-cycle Rdy_Low (with Err_Low on timeout), then back to IDLE
module mem_block_adapter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Req_Low,
    input  logic         Wr_Low,
    input  logic [27:0]  A_Low,
    input  logic [127:0] Din_Low,
    output logic         Rdy_Low,
    output logic         Err_Low,
    output logic [127:0] Dout_Low,
    output logic         Mem_Req,
    output logic         Mem_Wr,
    output logic [31:0]  Mem_Addr,
    output logic [31:0]  Mem_WData,
    input  logic [31:0]  Mem_RData,
    input  logic         Mem_Ack
);

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     beat_q, beat_d;
    logic [7:0]     stall_q, stall_d;
    logic [27:0]    addr_q, addr_d;
    logic           wr_q, wr_d;
    logic [127:0]   data_q, data_d;
    logic           err_q, err_d;
    logic           rdy_low_q, rdy_low_d;
    logic           err_low_q, err_low_d;
    logic [127:0]   dout_q, dout_d;
    logic           mem_req_q, mem_req_d;
    logic           mem_wr_q, mem_wr_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [31:0]    mem_wdata_q, mem_wdata_d;

    // Next-state, counters, captured fill data and the registered port values.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        stall_d     = stall_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        data_d      = data_q;
        err_d       = err_q;
        dout_d      = dout_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_req_d   = 1'b0;
        rdy_low_d   = 1'b0;
        err_low_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Req_Low) begin
                    addr_d  = A_Low;
                    wr_d    = Wr_Low;
                    data_d  = Din_Low;
                    beat_d  = 2'd0;
                    stall_d = 8'd0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (Mem_Ack) begin
                    if (!wr_q) begin
                        dout_d[{beat_q, 5'd0} +: 32] = Mem_RData;
                    end
                    stall_d = 8'd0;
                    if (beat_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else begin
                    stall_d = stall_q + 8'd1;
                    if (stall_d == TIMEOUT_CNT) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Port values are registered, so they follow the state being entered.
        if (state_d == XFER) begin
            mem_req_d   = 1'b1;
            mem_wr_d    = wr_d;
            mem_addr_d  = {addr_d, beat_d, 2'b00};
            mem_wdata_d = data_d[{beat_d, 5'd0} +: 32];
        end
        if (state_d == DONE) begin
            rdy_low_d = 1'b1;
            err_low_d = err_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            stall_q     <= 8'd0;
            addr_q      <= 28'd0;
            wr_q        <= 1'b0;
            data_q      <= 128'd0;
            err_q       <= 1'b0;
            rdy_low_q   <= 1'b0;
            err_low_q   <= 1'b0;
            dout_q      <= 128'd0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            stall_q     <= stall_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            err_q       <= err_d;
            rdy_low_q   <= rdy_low_d;
            err_low_q   <= err_low_d;
            dout_q      <= dout_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign Rdy_Low   = rdy_low_q;
    assign Err_Low   = err_low_q;
    assign Dout_Low  = dout_q;
    assign Mem_Req   = mem_req_q;
    assign Mem_Wr    = mem_wr_q;
    assign Mem_Addr  = mem_addr_q;
    assign Mem_WData = mem_wdata_q;

endmodule
